pcs_257b_scrambler: RTL and testbench

Stream scrambler for 257-bit transcoded PCS blocks. It sits directly downstream of the per-lane PCS generator's transcoder output and applies the self-synchronizing x^58 + x^39 + 1 scrambler across all 257 bits of each block. Input and output use valid/ready handshakes, and a two-entry skid buffer keeps the upstream ready registered. One instance serves one parallel word lane; the parallel wrapper replicates it per lane.

---
 rtl/pcs_gen_pkg.sv | 37 +++
 rtl/pcs_skid_buffer.sv | 71 +++++++
 rtl/pcs_257b_scrambler.sv | 81 ++++++++
 tb/tb_pcs_257b_scrambler.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_gen_pkg.sv
// Shared PCS generator constants and the 257-bit x^58 + x^39 + 1 scrambler unroll.
// Also used by the descrambler checker model, so keep scr_257 free of module state.
package pcs_gen_pkg;

    localparam int NB_FRAME_IN  = 257;
    localparam int NB_SCR_STATE = 58;
    localparam int SCR_TAP      = 39;
    localparam int NB_BLOCK_CNT = 32;

    localparam logic [NB_SCR_STATE-1:0] SCR_SEED = 58'h3FF_FFFF_FFFF_FFFF;

    typedef logic [NB_FRAME_IN-1:0]  blk_t;
    typedef logic [NB_SCR_STATE-1:0] scr_state_t;

    typedef struct packed {
        scr_state_t next_state;
        blk_t       blk;
    } scr_res_t;

    // hist holds the prior state in its low bits followed by the freshly
    // scrambled bits, so hist[k] is s[k-58] and hist[k+19] is s[k-39].
    function automatic scr_res_t scr_257(input blk_t block, input scr_state_t state);
        logic [NB_FRAME_IN+NB_SCR_STATE-1:0] hist;
        scr_res_t                            res;
        hist                     = '0;
        hist[NB_SCR_STATE-1:0]   = state;
        for (int k = 0; k < NB_FRAME_IN; k++) begin
            hist[k+NB_SCR_STATE] = block[k]
                                 ^ hist[k+NB_SCR_STATE-SCR_TAP]
                                 ^ hist[k];
        end
        res.blk        = hist[NB_FRAME_IN+NB_SCR_STATE-1:NB_SCR_STATE];
        res.next_state = hist[NB_FRAME_IN+NB_SCR_STATE-1 -: NB_SCR_STATE];
        return res;
    endfunction

endpackage

// File: rtl/pcs_skid_buffer.sv
// Two-entry valid/ready skid buffer: output register plus one skid register.
// Latency: 1 cycle input to output when not stalled.
// Backpressure: in_rdy is registered and drops only once the skid entry is occupied.
module pcs_skid_buffer #(
    parameter int W = 257
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_dat,
    input  logic         in_vld,
    output logic         in_rdy,
    output logic [W-1:0] out_dat,
    output logic         out_vld,
    input  logic         out_rdy
);

    logic [W-1:0] out_dat_q,  out_dat_d;
    logic [W-1:0] skid_dat_q, skid_dat_d;
    logic         out_vld_q,  out_vld_d;
    logic         skid_vld_q, skid_vld_d;
    logic         rdy_q,      rdy_d;
    logic         in_acc;
    logic         out_free;

    always_comb begin
        in_acc     = in_vld && rdy_q;
        out_free   = !out_vld_q || out_rdy;
        out_dat_d  = out_dat_q;
        out_vld_d  = out_vld_q;
        skid_dat_d = skid_dat_q;
        skid_vld_d = skid_vld_q;
        if (out_free) begin
            // A full skid always has priority; in_acc is impossible then.
            if (skid_vld_q) begin
                out_dat_d  = skid_dat_q;
                out_vld_d  = 1'b1;
                skid_vld_d = 1'b0;
            end else if (in_acc) begin
                out_dat_d = in_dat;
                out_vld_d = 1'b1;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (in_acc) begin
            skid_dat_d = in_dat;
            skid_vld_d = 1'b1;
        end
        rdy_d = !skid_vld_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_dat_q  <= '0;
            skid_dat_q <= '0;
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b1;
        end else begin
            out_dat_q  <= out_dat_d;
            skid_dat_q <= skid_dat_d;
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= rdy_d;
        end
    end

    assign in_rdy  = rdy_q;
    assign out_dat = out_dat_q;
    assign out_vld = out_vld_q;

endmodule

// File: rtl/pcs_257b_scrambler.sv
// Self-synchronizing x^58 + x^39 + 1 scrambler over 257-bit blocks; 1-cycle latency.
// Backpressure via a two-entry skid buffer with registered o_ready; PCS_SCR_BYPASS_EN adds i_bypass.
module pcs_257b_scrambler
    import pcs_gen_pkg::*;
#(
    parameter int                               NB_FRAME_IN  = pcs_gen_pkg::NB_FRAME_IN,
    parameter int                               NB_SCR_STATE = pcs_gen_pkg::NB_SCR_STATE,
    parameter logic [NB_SCR_STATE-1:0]          SCR_SEED     = pcs_gen_pkg::SCR_SEED,
    parameter int                               NB_BLOCK_CNT = pcs_gen_pkg::NB_BLOCK_CNT
) (
    input  logic                    clk,
    input  logic                    i_rst_n,
    input  logic [NB_FRAME_IN-1:0]  i_tx_coded,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic                    i_seed_load,
`ifdef PCS_SCR_BYPASS_EN
    input  logic                    i_bypass,
`endif
    output logic [NB_FRAME_IN-1:0]  o_tx_scr,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [NB_BLOCK_CNT-1:0] o_block_cnt
);

    logic [NB_SCR_STATE-1:0] state_q, state_d;
    logic [NB_BLOCK_CNT-1:0] cnt_q,   cnt_d;
    logic [NB_FRAME_IN-1:0]  blk_out;
    scr_res_t                scr;
    logic                    acc;

    always_comb begin
        scr = scr_257(i_tx_coded, state_q);
        acc = i_valid && o_ready;
`ifdef PCS_SCR_BYPASS_EN
        // State still advances on bypassed blocks to stay aligned with a reference scrambler.
        blk_out = i_bypass ? i_tx_coded : scr.blk;
`else
        blk_out = scr.blk;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (acc) begin
            state_d = scr.next_state;
            cnt_d   = cnt_q + NB_BLOCK_CNT'(1);
        end
        // Seed wins over the post-block state; the accepted block already used the old one.
        if (i_seed_load) begin
            state_d = SCR_SEED;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= SCR_SEED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    pcs_skid_buffer #(
        .W (NB_FRAME_IN)
    ) u_skid (
        .clk     (clk),
        .rst_n   (i_rst_n),
        .in_dat  (blk_out),
        .in_vld  (i_valid),
        .in_rdy  (o_ready),
        .out_dat (o_tx_scr),
        .out_vld (o_valid),
        .out_rdy (i_ready)
    );

    assign o_block_cnt = cnt_q;

endmodule

// File: tb/tb_pcs_257b_scrambler.sv
// Randomized bench for pcs_257b_scrambler against a bit-serial reference scrambler.
module tb_pcs_257b_scrambler;

    localparam logic [57:0] SEED = 58'h3FF_FFFF_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         i_rst_n;
    logic [256:0] i_tx_coded;
    logic         i_valid;
    logic         o_ready;
    logic         i_seed_load;
    logic [256:0] o_tx_scr;
    logic         o_valid;
    logic         i_ready;
    logic [31:0]  o_block_cnt;

    logic [256:0] z_tx_coded;
    logic         z_valid;
    logic         z_o_ready;
    logic [256:0] z_tx_scr;
    logic         z_o_valid;
    logic [3:0]   z_block_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pcs_257b_scrambler dut (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_tx_coded  (i_tx_coded),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_seed_load (i_seed_load),
`ifdef PCS_SCR_BYPASS_EN
        .i_bypass    (1'b0),
`endif
        .o_tx_scr    (o_tx_scr),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_block_cnt (o_block_cnt)
    );

    pcs_257b_scrambler #(
        .SCR_SEED     ('0),
        .NB_BLOCK_CNT (4)
    ) dut_z (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_tx_coded  (z_tx_coded),
        .i_valid     (z_valid),
        .o_ready     (z_o_ready),
        .i_seed_load (1'b0),
`ifdef PCS_SCR_BYPASS_EN
        .i_bypass    (1'b0),
`endif
        .o_tx_scr    (z_tx_scr),
        .o_valid     (z_o_valid),
        .i_ready     (1'b1),
        .o_block_cnt (z_block_cnt)
    );

    task automatic chk(input string tag, input logic [256:0] obs, input logic [256:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Serial reference: a sliding window of the last 58 transmitted scrambled bits.
    function automatic logic [256:0] ref_scramble(input logic [256:0] blk, input logic [57:0] st_in,
                                                  output logic [57:0] st_out);
        bit           hist[$];
        logic [256:0] o;
        for (int i = 0; i < 58; i++) hist.push_back(st_in[i]);
        for (int k = 0; k < 257; k++) begin
            bit b;
            b    = blk[k] ^ hist[19] ^ hist[0];
            o[k] = b;
            hist.push_back(b);
            void'(hist.pop_front());
        end
        for (int i = 0; i < 58; i++) st_out[i] = hist[i];
        return o;
    endfunction

    function automatic logic [256:0] rand_blk();
        logic [287:0] t;
        for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom;
        return t[256:0];
    endfunction

    // Scoreboard for the main instance: expected blocks queued at accept, popped at transfer.
    logic [256:0] exp_q[$];
    logic [57:0]  m_state   = SEED;
    bit           prev_stall = 1'b0;
    logic [256:0] prev_dat;

    always @(negedge clk) begin
        if (!i_rst_n) begin
            exp_q.delete();
            m_state    = SEED;
            prev_stall = 1'b0;
        end else begin
            logic [57:0] ns;
            if (prev_stall) begin
                chk("hold_vld", o_valid, 1);
                chk("hold_dat", o_tx_scr, prev_dat);
            end
            prev_stall = o_valid && !i_ready;
            prev_dat   = o_tx_scr;
            if (o_valid && i_ready) begin
                chk("sb_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("sb_data", o_tx_scr, exp_q.pop_front());
            end
            if (i_valid && o_ready) begin
                exp_q.push_back(ref_scramble(i_tx_coded, m_state, ns));
                m_state = i_seed_load ? SEED : ns;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [256:0] blk, input logic sl);
        int n;
        n          = 0;
        i_valid    = 1'b1;
        i_tx_coded = blk;
        while (!o_ready && n < 100) begin
            step();
            n++;
        end
        chk("send_timeout", n < 100, 1);
        i_seed_load = sl;
        step();
        i_seed_load = 1'b0;
        i_valid     = 1'b0;
    endtask

    task automatic zsend(input logic [256:0] blk);
        z_valid    = 1'b1;
        z_tx_coded = blk;
        step();
        z_valid    = 1'b0;
    endtask

    initial begin
        logic [256:0] b, b11, imp;
        logic [57:0]  ns, zst;

        i_rst_n     = 1'b1;
        i_tx_coded  = '0;
        i_valid     = 1'b0;
        i_seed_load = 1'b0;
        i_ready     = 1'b1;
        z_tx_coded  = '0;
        z_valid     = 1'b0;
        #1 i_rst_n  = 1'b0;
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_ready", o_ready, 1);
        chk("rst_data",  o_tx_scr, 0);
        chk("rst_cnt",   o_block_cnt, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 i_rst_n = 1'b1;
        step();

        // Seed-0 instance: zero propagation, impulse response, counter wrap.
        zsend('0);
        chk("zero_out", z_tx_scr, 0);
        zsend('0);
        chk("zero_keep", z_tx_scr, 0);
        imp = '0;
        imp[0] = 1'b1;
        zsend(imp);
        chk("imp_b0",  z_tx_scr[0],  1);
        chk("imp_b39", z_tx_scr[39], 1);
        chk("imp_b58", z_tx_scr[58], 1);
        chk("imp_b78", z_tx_scr[78], 1);
        chk("imp_b97", z_tx_scr[97], 0);
        chk("imp_full", z_tx_scr, ref_scramble(imp, '0, zst));
        for (int i = 3; i < 16; i++) begin
            b = rand_blk();
            zsend(b);
            chk("z_rand", z_tx_scr, ref_scramble(b, zst, ns));
            zst = ns;
            if (i == 14) chk("z_cnt15", z_block_cnt, 15);
        end
        chk("z_cnt_wrap", z_block_cnt, 0);

        // Streaming with i_ready high.
        b = rand_blk();
        send(b, 0);
        chk("first_lat", o_valid, 1);
        chk("first_dat", o_tx_scr, ref_scramble(b, SEED, ns));
        for (int i = 1; i < 1000; i++) send(rand_blk(), 0);
        repeat (3) step();
        chk("cnt_1000", o_block_cnt, 1000);
        chk("drained_vld", o_valid, 0);

        // Backpressure: 5 stalled edges.
        i_ready    = 1'b0;
        i_valid    = 1'b1;
        i_tx_coded = rand_blk();
        step();
        chk("bp_rdy_a", o_ready, 1);
        chk("bp_vld_a", o_valid, 1);
        i_tx_coded = rand_blk();
        step();
        chk("bp_rdy_drop", o_ready, 0);
        i_tx_coded = rand_blk();
        repeat (3) begin
            step();
            chk("bp_rdy_low", o_ready, 0);
        end
        i_ready = 1'b1;
        step();
        chk("bp_rdy_rise", o_ready, 1);
        step();
        i_valid = 1'b0;
        repeat (3) step();
        chk("bp_cnt", o_block_cnt, 1003);

        // Seed load on block 10.
        for (int i = 0; i < 12; i++) begin
            b = rand_blk();
            if (i == 11) b11 = b;
            send(b, i == 10);
        end
        chk("seed_blk11", o_tx_scr, ref_scramble(b11, SEED, ns));
        repeat (2) step();

        // Asynchronous reset while stalled with both entries full.
        i_ready = 1'b0;
        send(rand_blk(), 0);
        send(rand_blk(), 0);
        chk("pre_rst_rdy", o_ready, 0);
        #3 i_rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", o_valid, 0);
        chk("mid_rst_rdy", o_ready, 1);
        chk("mid_rst_dat", o_tx_scr, 0);
        chk("mid_rst_cnt", o_block_cnt, 0);
        i_ready = 1'b1;
        @(negedge clk);
        #2 i_rst_n = 1'b1;
        step();
        b = rand_blk();
        send(b, 0);
        chk("post_rst_dat", o_tx_scr, ref_scramble(b, SEED, ns));
        chk("post_rst_cnt", o_block_cnt, 1);

        repeat (3) step();
        chk("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
